// File: rtl/ssm_sample.sv
// Packet-level 1-in-N sampler: forwards whole selected packets with one cycle of latency
// and holds an idle gap after each forwarded tail. Head counters are built only with SSM_SAMPLE_CNT_EN.
module ssm_sample #(
    parameter int GAP_CYCLES = 4,
    parameter int RATIO_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_sample_en,
    input  logic [RATIO_W-1:0] iv_sample_ratio,
    input  logic [133:0]       pktin_data,
    input  logic               pktin_data_wr,
    output logic [133:0]       pktout_data,
    output logic               pktout_data_wr,
    output logic               o_busy,
    output logic [31:0]        ov_sampled_cnt,
    output logic [31:0]        ov_dropped_cnt
);

    typedef enum logic [1:0] {IDLE, PASS, DISCARD} state_t;

    localparam int               GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [1:0]       FLAG_HEAD = 2'b01;
    localparam logic [1:0]       FLAG_TAIL = 2'b10;
    localparam logic [133:0]     SYN_TAIL  = {2'b10, 132'h0};
    localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);

    state_t             r_state, w_state_next;
    logic [RATIO_W-1:0] r_pkt_cnt, w_pkt_cnt_next, w_pkt_cnt_adv;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_next, w_gap_cnt_dec;
    logic [133:0]       r_out_data, w_out_data_next;
    logic               r_out_wr, w_out_wr_next;

    logic w_is_head, w_is_tail, w_slot_due, w_gap_clear, w_select;

    assign w_is_head   = pktin_data_wr && (pktin_data[133:132] == FLAG_HEAD);
    assign w_is_tail   = pktin_data_wr && (pktin_data[133:132] == FLAG_TAIL);
    assign w_slot_due  = i_sample_en && (r_pkt_cnt == '0);
    assign w_gap_clear = (r_gap_cnt == '0);
    assign w_select    = w_slot_due && w_gap_clear;

    // >= rather than == so a lowered ratio wraps at the next head instead of after a full count
    assign w_pkt_cnt_adv = ((iv_sample_ratio <= RATIO_ONE) || (r_pkt_cnt >= iv_sample_ratio - RATIO_ONE))
                           ? '0 : r_pkt_cnt + RATIO_ONE;
    assign w_gap_cnt_dec = w_gap_clear ? '0 : r_gap_cnt - GAP_W'(1);

    always_comb begin
        w_state_next    = r_state;
        w_pkt_cnt_next  = r_pkt_cnt;
        w_gap_cnt_next  = w_gap_cnt_dec;
        w_out_wr_next   = 1'b0;
        w_out_data_next = r_out_data;
        if (pktin_data_wr) begin
            if (r_state == PASS) begin
                if (w_is_head) begin
                    // Close the truncated packet downstream; the new head is not sampled
                    w_out_wr_next   = 1'b1;
                    w_out_data_next = SYN_TAIL;
                    w_gap_cnt_next  = GAP_LOAD;
                    w_state_next    = DISCARD;
                end else begin
                    w_out_wr_next   = 1'b1;
                    w_out_data_next = pktin_data;
                    if (w_is_tail) begin
                        w_gap_cnt_next = GAP_LOAD;
                        w_state_next   = IDLE;
                    end
                end
            end else if (w_is_head) begin
                if (w_select) begin
                    w_out_wr_next   = 1'b1;
                    w_out_data_next = pktin_data;
                    w_state_next    = PASS;
                end else begin
                    w_state_next = DISCARD;
                end
                // A slot blocked only by the gap is kept for the next head
                if (!(w_slot_due && !w_gap_clear)) begin
                    w_pkt_cnt_next = w_pkt_cnt_adv;
                end
            end else if (w_is_tail) begin
                w_state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pkt_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_out_data <= '0;
            r_out_wr   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pkt_cnt  <= w_pkt_cnt_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_out_data <= w_out_data_next;
            r_out_wr   <= w_out_wr_next;
        end
    end

    assign pktout_data    = r_out_data;
    assign pktout_data_wr = r_out_wr;
    assign o_busy         = (r_state == PASS) || !w_gap_clear;

`ifdef SSM_SAMPLE_CNT_EN
    logic [31:0] r_sampled_cnt, r_dropped_cnt;
    logic        w_sampled_inc, w_dropped_inc;

    assign w_sampled_inc = w_is_head && (r_state != PASS) && w_select;
    assign w_dropped_inc = w_is_head && !w_sampled_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampled_cnt <= '0;
            r_dropped_cnt <= '0;
        end else begin
            if (w_sampled_inc && (r_sampled_cnt != 32'hFFFF_FFFF)) begin
                r_sampled_cnt <= r_sampled_cnt + 32'd1;
            end
            if (w_dropped_inc && (r_dropped_cnt != 32'hFFFF_FFFF)) begin
                r_dropped_cnt <= r_dropped_cnt + 32'd1;
            end
        end
    end

    assign ov_sampled_cnt = r_sampled_cnt;
    assign ov_dropped_cnt = r_dropped_cnt;
`else
    assign ov_sampled_cnt = 32'd0;
    assign ov_dropped_cnt = 32'd0;
`endif

endmodule
